// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Holds the fetch PC, selects the next
//                PC from branch / jump redirects, hazard hold or sequential
//                PC+4, and drives the IF/ID pipeline register with bubble,
//                hold and load behaviour. Two saturating performance counters
//                record hold cycles and flush cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCWrite,
    input  logic             WriteIFID,
    input  logic             flushifid,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [2:0]       JumpInstC,
    input  logic [31:0]      jump_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc_if,
    output logic [31:0]      instr_id,
    output logic [31:0]      pcplus4_id,
    output logic             valid_id,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_pc;
    logic [31:0]       r_instr;
    logic [31:0]       r_pcplus4;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_is_jump;
    logic              w_redirect;
    logic              w_hold_req;
    logic [31:0]       w_pc_plus4;
    logic [31:0]       w_branch_tgt;
    logic [31:0]       w_jump_tgt;
    logic [31:0]       w_pc_nxt;
    logic              w_ifid_bubble;
    logic              w_ifid_load;
    logic              w_stall_inc;
    logic              w_flush_inc;

    // Redirect decode and address arithmetic; targets are word-aligned here
    // so the PC can never hold a misaligned fetch address.
    always_comb begin
        w_is_jump    = (JumpInstC == 3'd1) || (JumpInstC == 3'd2);
        w_redirect   = branch_taken || w_is_jump;
        w_hold_req   = PCWrite && !w_redirect;
        w_pc_plus4   = r_pc + 32'd4;
        w_branch_tgt = {branch_target[31:2], 2'b00};
        w_jump_tgt   = {jump_target[31:2], 2'b00};
        w_flush_inc  = flushifid || branch_taken;
    end

    // Next-state, next-PC and IF/ID control for the BOOT/RUN/HOLD machine.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ifid_bubble = 1'b0;
        w_ifid_load   = 1'b0;
        w_stall_inc   = 1'b0;

        case (r_state)
            ST_BOOT: begin
                // First cycle out of reset: PC parked, IF/ID gets a bubble.
                w_state_nxt   = ST_RUN;
                w_pc_nxt      = RESET_PC;
                w_ifid_bubble = 1'b1;
            end
            ST_RUN, ST_HOLD: begin
                if (w_hold_req) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
                w_stall_inc = w_hold_req;

                // A redirect always wins over a hold request.
                if (branch_taken) begin
                    w_pc_nxt = w_branch_tgt;
                end else if (w_is_jump) begin
                    w_pc_nxt = w_jump_tgt;
                end else if (PCWrite) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_pc_nxt = w_pc_plus4;
                end

                // A taken branch squashes the wrong-path fetch in IF/ID.
                if (flushifid || branch_taken) begin
                    w_ifid_bubble = 1'b1;
                end else if (!WriteIFID) begin
                    w_ifid_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_BOOT;
                w_pc_nxt      = RESET_PC;
                w_ifid_bubble = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    // IF/ID pipeline register: bubble, hold, or capture the current fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= 32'h0;
            r_pcplus4 <= 32'h0;
            r_valid   <= 1'b0;
        end else if (w_ifid_bubble) begin
            r_instr   <= 32'h0;
            r_pcplus4 <= 32'h0;
            r_valid   <= 1'b0;
        end else if (w_ifid_load) begin
            r_instr   <= imem_rdata;
            r_pcplus4 <= w_pc_plus4;
            r_valid   <= 1'b1;
        end
    end

    // Saturating count of cycles the PC was held by a hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    // Saturating count of cycles in which IF/ID was flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
        end else if (w_flush_inc && (r_flush_cnt != c_cnt_max)) begin
            r_flush_cnt <= r_flush_cnt + c_cnt_one;
        end
    end

    // Output mapping; the memory address is the fetch PC itself.
    always_comb begin
        pc_if       = r_pc;
        imem_addr   = r_pc;
        instr_id    = r_instr;
        pcplus4_id  = r_pcplus4;
        valid_id    = r_valid;
        stall_count = r_stall_cnt;
        flush_count = r_flush_cnt;
    end

endmodule
`default_nettype wire
